// File: rtl/i2d_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2d_core_pkg
// Purpose  : Shared core definitions: default register-file geometry, the
//            architectural data/address types and the register-file
//            controller state encodings.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package i2d_core_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 16;
   localparam int REG_ADDR_W   = $clog2(NUM_REGS_DEF);

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Register-file controller states: clear sweep, then normal operation.
   localparam logic [0:0] RF_ST_INIT = 1'b0;
   localparam logic [0:0] RF_ST_RUN  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/core_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : core_rf_scoreboard
// Purpose  : Per-register pending bits. A write clears the bit of its
//            address, an issue sets the bit of its destination; when both
//            target the same register in one cycle the issue wins.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            upd_en         - allow updates (controller in RUN)
//            wr_vld/wr_addr - range-qualified write strobes and addresses
//            iss_vld/iss_addr - range-qualified issue strobe and address
//            pend_view      - pending vector as seen by the read ports
//                             (current, or post-update when POST_VIEW=1)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module core_rf_scoreboard #(
   parameter int NUM_REGS  = 16,
   parameter int NWR       = 2,
   parameter int AW        = 4,
   parameter bit POST_VIEW = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     upd_en,
   input  logic [NWR-1:0]           wr_vld,
   input  logic [NWR-1:0][AW-1:0]   wr_addr,
   input  logic                     iss_vld,
   input  logic [AW-1:0]            iss_addr,
   output logic [NUM_REGS-1:0]      pend_view
);

   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] w_pend_nxt;

   // Clears are applied first so a same-cycle issue to the same register
   // leaves the bit set.
   always_comb begin
      w_pend_nxt = r_pend;
      if (upd_en) begin
         for (int i = 0; i < NWR; i++) begin
            if (wr_vld[i]) begin
               w_pend_nxt[wr_addr[i]] = 1'b0;
            end
         end
         if (iss_vld) begin
            w_pend_nxt[iss_addr] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_nxt;
      end
   end

   generate
      if (POST_VIEW) begin : g_post_view
         assign pend_view = w_pend_nxt;
      end else begin : g_pre_view
         assign pend_view = r_pend;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/core_rf_gpr_mp.sv
`default_nettype none
// ============================================================================
// Module   : core_rf_gpr_mp
// Purpose  : Multi-ported general-purpose register file with per-register
//            pending (scoreboard) bits and a post-reset clear sweep.
//            After reset the controller clears one register per cycle
//            (INIT), then serves registered reads and prioritised writes
//            (RUN). Among same-cycle writes to one address the highest port
//            index wins.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            rd_addr/rd_data/rd_pend - NRD registered read ports
//            wr_en/wr_addr/wr_data   - NWR write ports
//            iss_en/iss_addr     - mark a destination register pending
//            init_busy           - high while the clear sweep runs
// Config   : I2D_RF_BYPASS_EN - when defined, a read colliding with a write
//            in the same cycle returns the new data and post-update pending
//            bit; otherwise reads are read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
module core_rf_gpr_mp
   import i2d_core_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NRD      = 2,
   parameter int NWR      = 2,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NRD-1:0][AW-1:0]       rd_addr,
   output logic [NRD-1:0][DATA_W-1:0]   rd_data,
   output logic [NRD-1:0]               rd_pend,
   input  logic [NWR-1:0]               wr_en,
   input  logic [NWR-1:0][AW-1:0]       wr_addr,
   input  logic [NWR-1:0][DATA_W-1:0]   wr_data,
   input  logic                         iss_en,
   input  logic [AW-1:0]                iss_addr,
   output logic                         init_busy
);

`ifdef I2D_RF_BYPASS_EN
   localparam bit c_bypass = 1'b1;
`else
   localparam bit c_bypass = 1'b0;
`endif

   // One extra bit so NUM_REGS itself is representable for range checks.
   localparam logic [AW:0]   c_num_regs = (AW+1)'(NUM_REGS);
   localparam logic [AW-1:0] c_last_idx = AW'(NUM_REGS-1);

   logic [0:0]        r_state;
   logic [AW-1:0]     r_cnt;
   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_run;
   logic [NWR-1:0]    w_wr_ok;
   logic              w_iss_ok;
   logic [NUM_REGS-1:0] w_pend_view;

   assign w_run     = (r_state == RF_ST_RUN);
   assign init_busy = ~w_run;
   assign w_iss_ok  = iss_en && ({1'b0, iss_addr} < c_num_regs);

   generate
      for (genvar i = 0; i < NWR; i++) begin : g_wr_qual
         assign w_wr_ok[i] = wr_en[i] && ({1'b0, wr_addr[i]} < c_num_regs);
      end
   endgenerate

   // Sweep controller: exactly NUM_REGS INIT cycles, index = counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RF_ST_INIT;
         r_cnt   <= '0;
      end else if (r_state == RF_ST_INIT) begin
         if (r_cnt == c_last_idx) begin
            r_state <= RF_ST_RUN;
            r_cnt   <= '0;
         end else begin
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   // Storage array is deliberately not reset; the sweep zeroes it. The
   // ascending port loop makes the highest-index write the last assignment.
   always_ff @(posedge clk) begin
      if (!w_run) begin
         r_regs[r_cnt] <= '0;
      end else begin
         for (int i = 0; i < NWR; i++) begin
            if (w_wr_ok[i]) begin
               r_regs[wr_addr[i]] <= wr_data[i];
            end
         end
      end
   end

   core_rf_scoreboard #(
      .NUM_REGS  (NUM_REGS),
      .NWR       (NWR),
      .AW        (AW),
      .POST_VIEW (c_bypass)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .upd_en    (w_run),
      .wr_vld    (w_wr_ok),
      .wr_addr   (wr_addr),
      .iss_vld   (w_iss_ok),
      .iss_addr  (iss_addr),
      .pend_view (w_pend_view)
   );

   generate
      for (genvar r = 0; r < NRD; r++) begin : g_rd_port
         logic              w_rd_ok;
         logic [DATA_W-1:0] w_rd_val;
         logic              w_rd_pnd;

         assign w_rd_ok = ({1'b0, rd_addr[r]} < c_num_regs);

         always_comb begin
            w_rd_val = '0;
            w_rd_pnd = 1'b0;
            if (w_rd_ok) begin
               w_rd_val = r_regs[rd_addr[r]];
               w_rd_pnd = w_pend_view[rd_addr[r]];
               if (c_bypass) begin
                  for (int i = 0; i < NWR; i++) begin
                     if (w_wr_ok[i] && (wr_addr[i] == rd_addr[r])) begin
                        w_rd_val = wr_data[i];
                     end
                  end
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rd_data[r] <= '0;
               rd_pend[r] <= 1'b0;
            end else if (!w_run) begin
               rd_data[r] <= '0;
               rd_pend[r] <= 1'b0;
            end else begin
               rd_data[r] <= w_rd_val;
               rd_pend[r] <= w_rd_pnd;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_core_rf_gpr_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_rf_gpr_mp
// Purpose  : Directed self-checking bench for core_rf_gpr_mp (default
//            geometry: 32-bit data, 16 registers, 2 read / 2 write ports).
// Ports    : none
// Config   : I2D_RF_BYPASS_EN selects the expected same-cycle read result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_rf_gpr_mp;

   localparam int DW = 32;
   localparam int NR = 16;
   localparam int AW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [1:0][AW-1:0]   rd_addr = '0;
   logic [1:0][DW-1:0]   rd_data;
   logic [1:0]           rd_pend;
   logic [1:0]           wr_en = '0;
   logic [1:0][AW-1:0]   wr_addr = '0;
   logic [1:0][DW-1:0]   wr_data = '0;
   logic                 iss_en = 1'b0;
   logic [AW-1:0]        iss_addr = '0;
   logic                 init_busy;

   int n_checks = 0;
   int n_fail   = 0;

   core_rf_gpr_mp #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .NRD      (2),
      .NWR      (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_pend   (rd_pend),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .init_busy (init_busy)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_init(output int cycles);
      cycles = 0;
      while (init_busy && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      int cyc;
      rst = 1'b1;
      tick(); tick();
      n_checks++;
      if (rd_data[0] !== 32'h0 || rd_pend[0] !== 1'b0 || init_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_outputs: data=%h pend=%b busy=%b, want 0/0/1",
                  rd_data[0], rd_pend[0], init_busy);
      end
      // Release reset; during the sweep drive writes/issue that must be ignored.
      rst = 1'b0;
      wr_en = 2'b01; wr_addr[0] = 4'd15; wr_data[0] = 32'hFFFF_FFFF;
      iss_en = 1'b1; iss_addr = 4'd15;
      rd_addr[0] = 4'd15;
      tick();
      n_checks++;
      if (rd_data[0] !== 32'h0 || init_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL init_read_zero: data=%h busy=%b, want 0/1", rd_data[0], init_busy);
      end
      wait_init(cyc);
      cyc++;
      wr_en = '0; iss_en = 1'b0;
      n_checks++;
      if (cyc !== 16) begin
         n_fail++;
         $display("FAIL init_length: %0d cycles, want 16", cyc);
      end
      for (int r = 0; r < NR; r++) begin
         rd_addr[0] = AW'(r);
         rd_addr[1] = AW'(NR - 1 - r);
         tick();
         n_checks++;
         if (rd_data[0] !== 32'h0 || rd_pend[0] !== 1'b0 ||
             rd_data[1] !== 32'h0 || rd_pend[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_r%0d: p0 %h/%b p1 %h/%b, want all 0",
                     r, rd_data[0], rd_pend[0], rd_data[1], rd_pend[1]);
         end
      end
   endtask

   task automatic test_port_priority();
      wr_en = 2'b11;
      wr_addr[0] = 4'd3; wr_data[0] = 32'h1234;
      wr_addr[1] = 4'd3; wr_data[1] = 32'hBEEF;
      tick();
      wr_en = 2'b01; wr_addr[0] = 4'd4; wr_data[0] = 32'hCAFE_0004;
      tick();
      wr_en = '0;
      rd_addr[0] = 4'd3; rd_addr[1] = 4'd4;
      tick();
      n_checks++;
      if (rd_data[0] !== 32'hBEEF) begin
         n_fail++;
         $display("FAIL port_priority: r3=%h, want 0000beef", rd_data[0]);
      end
      n_checks++;
      if (rd_data[1] !== 32'hCAFE_0004) begin
         n_fail++;
         $display("FAIL port0_write: r4=%h, want cafe0004", rd_data[1]);
      end
   endtask

   task automatic test_pending();
      iss_en = 1'b1; iss_addr = 4'd5;
      tick();
      iss_en = 1'b0;
      rd_addr[0] = 4'd5;
      tick();
      n_checks++;
      if (rd_pend[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
         n_fail++;
         $display("FAIL pend_set: pend=%b data=%h, want 1/0", rd_pend[0], rd_data[0]);
      end
      wr_en = 2'b10; wr_addr[1] = 4'd5; wr_data[1] = 32'h55;
      tick();
      wr_en = '0;
      tick();
      n_checks++;
      if (rd_pend[0] !== 1'b0 || rd_data[0] !== 32'h55) begin
         n_fail++;
         $display("FAIL pend_clear: pend=%b data=%h, want 0/55", rd_pend[0], rd_data[0]);
      end
   endtask

   task automatic test_same_cycle_rw();
      logic [DW-1:0] exp_d;
      logic          exp_p;
`ifdef I2D_RF_BYPASS_EN
      exp_d = 32'hA5A5; exp_p = 1'b1;
`else
      exp_d = 32'h0;    exp_p = 1'b0;
`endif
      rd_addr[0] = 4'd7;
      wr_en = 2'b11;
      wr_addr[0] = 4'd7; wr_data[0] = 32'h1111;
      wr_addr[1] = 4'd7; wr_data[1] = 32'hA5A5;
      iss_en = 1'b1; iss_addr = 4'd7;
      tick();
      wr_en = '0; iss_en = 1'b0;
      n_checks++;
      if (rd_data[0] !== exp_d || rd_pend[0] !== exp_p) begin
         n_fail++;
         $display("FAIL same_cycle_rw: data=%h pend=%b, want %h/%b",
                  rd_data[0], rd_pend[0], exp_d, exp_p);
      end
      tick();
      n_checks++;
      if (rd_data[0] !== 32'hA5A5 || rd_pend[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL after_rw: data=%h pend=%b, want a5a5/1", rd_data[0], rd_pend[0]);
      end
   endtask

   task automatic test_iss_and_write();
      iss_en = 1'b1; iss_addr = 4'd9;
      wr_en = 2'b01; wr_addr[0] = 4'd9; wr_data[0] = 32'h9;
      tick();
      iss_en = 1'b0; wr_en = '0;
      rd_addr[1] = 4'd9;
      tick();
      n_checks++;
      if (rd_data[1] !== 32'h9 || rd_pend[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL iss_wins: data=%h pend=%b, want 9/1", rd_data[1], rd_pend[1]);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      iss_en = 1'b1; iss_addr = 4'd11;
      wr_en = 2'b01; wr_addr[0] = 4'd2; wr_data[0] = 32'h77;
      tick();
      iss_en = 1'b0; wr_en = '0;
      rd_addr[0] = 4'd2; rd_addr[1] = 4'd11;
      tick();
      n_checks++;
      if (rd_data[0] !== 32'h77 || rd_pend[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset: r2=%h pend11=%b, want 77/1", rd_data[0], rd_pend[1]);
      end
      // Reset takes effect without a clock edge.
      rst = 1'b1;
      #1;
      n_checks++;
      if (rd_data[0] !== 32'h0 || rd_pend[1] !== 1'b0 || init_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: data=%h pend=%b busy=%b, want 0/0/1",
                  rd_data[0], rd_pend[1], init_busy);
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      // Sweep counter is now 6; reset again.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_init(cyc);
      n_checks++;
      if (cyc !== 16) begin
         n_fail++;
         $display("FAIL restart_length: %0d cycles, want 16", cyc);
      end
      tick();
      n_checks++;
      if (rd_data[0] !== 32'h0 || rd_pend[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL post_restart: r2=%h pend11=%b, want 0/0", rd_data[0], rd_pend[1]);
      end
   endtask

   initial begin
      test_reset();
      test_port_priority();
      test_pending();
      test_same_cycle_rw();
      test_iss_and_write();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_rf_gpr_mp.md
CORE_RF_GPR_MP -- requirements
Module: core_rf_gpr_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of architectural registers (2..64).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port rd_addr  input  NRD x clog2(NUM_REGS)  read addresses.
REQ-008 SHALL have port rd_data  output  NRD x DATA_W  registered read data.
REQ-009 SHALL have port rd_pend  output  NRD  registered pending flag of the addressed register.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enables.
REQ-011 SHALL have port wr_addr  input  NWR x clog2(NUM_REGS)  write addresses.
REQ-012 SHALL have port wr_data  input  NWR x DATA_W  write data.
REQ-013 SHALL have port iss_en  input  1  marks register iss_addr pending (destination issued).
REQ-014 SHALL have port iss_addr  input  clog2(NUM_REGS)  issued destination.
REQ-015 SHALL have port init_busy  output  1  high while the clear sweep runs.

Function
REQ-016 SHALL implement FSM states INIT and RUN; rst forces INIT with sweep counter 0.
REQ-017 In INIT SHALL clear one register per cycle (index = counter), increment counter, and enter RUN after clearing index NUM_REGS-1 (exactly NUM_REGS cycles).
REQ-018 In INIT SHALL ignore wr_en and iss_en, hold init_busy=1, drive rd_data=0 and rd_pend=0.
REQ-019 In RUN SHALL set init_busy=0 and return rd_data/rd_pend one cycle after rd_addr is presented.
REQ-020 SHALL write wr_data[i] to wr_addr[i] on the edge where wr_en[i]=1 in RUN.
REQ-021 On simultaneous writes to the same address, the highest port index SHALL win.
REQ-022 A write SHALL clear the pending bit of its address; iss_en SHALL set the pending bit of iss_addr.
REQ-023 On iss_en and a write to the same address in one cycle, the pending bit SHALL end set and the data SHALL be written.
REQ-024 Addresses >= NUM_REGS SHALL be ignored for writes/issue and SHALL read data 0, pending 0.
REQ-025 rst asserted mid-sweep or mid-operation SHALL restart INIT from counter 0 and clear all pending bits.

Reset
REQ-026 On rst SHALL drive rd_data=0, rd_pend=0, init_busy=1, all pending bits 0; register contents SHALL be 0 once init_busy falls.

Configuration
REQ-027 With I2D_RF_BYPASS_EN defined, a read and a write to the same address in the same RUN cycle SHALL return the new data (winning port per REQ-021) and the post-update pending bit.
REQ-028 Without I2D_RF_BYPASS_EN, the same case SHALL return the pre-write data and pre-update pending bit (read-before-write).

Structure
REQ-029 data_t, reg_addr_t and the DATA_W/NUM_REGS defaults SHALL live in the shared package i2d_core_pkg.
REQ-030 Pending-bit tracking (set/clear/priority, REQ-022/023) SHALL be the sub-module core_rf_scoreboard.

Verification
REQ-031 Deassert rst, poll init_busy -> falls after exactly 16 cycles; reading all 16 registers returns 0, rd_pend 0.
REQ-032 Write port0 r3=0x1234 and port1 r3=0xBEEF same cycle, read r3 next cycle -> 0xBEEF.
REQ-033 iss_en r5, then read r5 -> rd_pend=1; write r5=0x55 -> next read rd_pend=0, data 0x55.
REQ-034 Same cycle write r7=0xA5A5 and read r7 (old 0) -> 0xA5A5 with I2D_RF_BYPASS_EN, 0 without.
REQ-035 Write r2=0x77, assert rst at sweep counter 6 -> init_busy held 16 further cycles; r2 reads 0.
REQ-036 iss_en r9 and write r9=0x9 same cycle -> next read r9 data 0x9, rd_pend=1.
